seg_scan_ctrl: RTL and testbench

- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Sequences one shared hex-to-segment decode path across N_DIG digits.
- Inserts a blanking gap between digit slots to suppress ghosting.
- Double-buffers display data so a value update never tears mid-frame.
- Sits between the datapath's hex value registers and the board anode/segment pins.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_scan_ctrl_if.sv | 24 ++
 rtl/seg_slot_timer.sv | 43 ++++
 rtl/seg_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g} = seg[6:0]; all patterns are active low.
package seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // Hex digit 0..F to active-low segment pattern
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side controls and board-side pins of the scan controller, bundled.
// master: the datapath/bench side; slave: the scan controller.
interface seg_scan_ctrl_if
    import seg_pkg::*;
#(
    parameter int unsigned N_DIG = 4
);
    logic                 en;
    logic                 load;
    logic [4*N_DIG-1:0]   data_in;
    logic [N_DIG-1:0]     an;
    logic [SEG_W-1:0]     seg;
    logic                 frame_done;

    modport master (
        output en, load, data_in,
        input  an, seg, frame_done
    );

    modport slave (
        input  en, load, data_in,
        output an, seg, frame_done
    );
endinterface

// File: rtl/seg_slot_timer.sv
// Slot timer: counts cycles within a digit slot and steps the digit index.
// Strobes are combinational on the current count; everything clears while
// i_en is low so a restart always begins at the blank of digit 0.
module seg_slot_timer #(
    parameter int unsigned N_DIG     = 4,
    parameter int unsigned SLOT_CYC  = 50000,
    parameter int unsigned BLANK_CYC = 16,
    parameter int unsigned IDX_W     = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic             o_blank_end,
    output logic             o_slot_end,
    output logic             o_wrap,
    output logic [IDX_W-1:0] o_idx
);
    localparam int unsigned CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;

    assign o_blank_end = i_en && (r_cnt == CNT_W'(BLANK_CYC - 1));
    assign o_slot_end  = i_en && (r_cnt == CNT_W'(SLOT_CYC - 1));
    assign o_wrap      = o_slot_end && (r_idx == IDX_W'(N_DIG - 1));
    assign o_idx       = r_idx;

    // Slot counter and digit index, held at zero while scanning is disabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (o_slot_end) begin
            r_cnt <= '0;
            r_idx <= o_wrap ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment driver with per-slot blanking and
// frame-boundary double buffering of the displayed value.
// Optional: define SEG_SCAN_LZB_EN for leading-zero blanking (digit 0 always lit).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned N_DIG     = 4,
    parameter int unsigned SLOT_CYC  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    seg_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_blank_end, w_slot_end, w_wrap;
    logic [4*N_DIG-1:0] r_shadow, r_pending;
    logic               r_pend;
    logic [N_DIG-1:0]   r_an, w_an_nxt;
    logic [SEG_W-1:0]   r_seg, w_seg_nxt;
    logic               r_frame_done;
    logic [3:0]         w_nib;

    seg_slot_timer #(
        .N_DIG     (N_DIG),
        .SLOT_CYC  (SLOT_CYC),
        .BLANK_CYC (BLANK_CYC),
        .IDX_W     (IDX_W)
    ) u_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (bus.en),
        .o_blank_end (w_blank_end),
        .o_slot_end  (w_slot_end),
        .o_wrap      (w_wrap),
        .o_idx       (w_idx)
    );

    // Next scan state: dark gap first, then the lit part of the slot
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.en) begin
            w_state_nxt = BLANK;
        end else begin
            unique case (r_state)
                BLANK:   if (w_blank_end) w_state_nxt = SHOW;
                SHOW:    if (w_slot_end)  w_state_nxt = BLANK;
                default: w_state_nxt = BLANK;
            endcase
        end
    end

    assign w_nib = r_shadow[4*w_idx +: 4];

`ifdef SEG_SCAN_LZB_EN
    logic [N_DIG-1:0] w_lead_zero;
    logic             w_zero_run;

    // Digit k is a leading zero when it and every higher nibble are zero
    always_comb begin
        w_lead_zero = '0;
        w_zero_run  = 1'b1;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            w_zero_run     = w_zero_run && (r_shadow[4*k +: 4] == 4'h0);
            w_lead_zero[k] = w_zero_run;
        end
    end
`endif

    // Pin values for the next cycle, derived from the current state and index
    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        if (bus.en && r_state == SHOW) begin
            w_an_nxt[w_idx] = 1'b0;
            w_seg_nxt       = SEG_TABLE[w_nib];
`ifdef SEG_SCAN_LZB_EN
            if (w_lead_zero[w_idx]) w_seg_nxt = SEG_OFF;
`endif
        end
    end

    // State and registered pins; an/seg share an edge so they never disagree
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= BLANK;
            r_an         <= '1;
            r_seg        <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_wrap;
        end
    end

    // Double buffer: shadow only changes at a frame boundary or while idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow  <= '0;
            r_pending <= '0;
            r_pend    <= 1'b0;
        end else if (bus.load && w_wrap) begin
            // A load landing on the wrap bypasses pending; any older pending is dropped
            r_shadow <= bus.data_in;
            r_pend   <= 1'b0;
        end else if (bus.load) begin
            r_pending <= bus.data_in;
            r_pend    <= 1'b1;
        end else if ((w_wrap || !bus.en) && r_pend) begin
            r_shadow <= r_pending;
            r_pend   <= 1'b0;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIG=4, SLOT_CYC=8, BLANK_CYC=2.
// Position j counts clock edges since en was first sampled high; after edge j
// the pins show digit (j%32)/8, lit only when j%8 >= 2, and frame_done is
// high when j%32 == 31.
module tb_seg_scan_ctrl;
    localparam int unsigned N_DIG = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg_scan_ctrl_if #(.N_DIG(N_DIG)) u_if ();

    seg_scan_ctrl #(
        .N_DIG     (N_DIG),
        .SLOT_CYC  (8),
        .BLANK_CYC (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [3:0] exp_an(input int j);
        logic [3:0] a;
        int p;
        p = j % 32;
        a = 4'hF;
        if ((p % 8) >= 2) a[p / 8] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_seg(input int j, input logic [15:0] d);
        int p;
        p = j % 32;
        if ((p % 8) < 2) return 7'b1111111;
        return tbl[d[(p / 8) * 4 +: 4]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop en for one edge (scan reset, pending copied) then re-enable
    task automatic restart();
        u_if.en = 1'b0;
        tick();
        u_if.en = 1'b1;
    endtask

    task automatic test_reset();
        u_if.en      = 1'b0;
        u_if.load    = 1'b0;
        u_if.data_in = '0;
        rst_n        = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (u_if.an !== 4'hF) begin
            n_err++; $display("FAIL reset_an got %b want 1111", u_if.an);
        end
        n_vec++;
        if (u_if.seg !== 7'b1111111) begin
            n_err++; $display("FAIL reset_seg got %b want 1111111", u_if.seg);
        end
        n_vec++;
        if (u_if.frame_done !== 1'b0) begin
            n_err++; $display("FAIL reset_fd got %b want 0", u_if.frame_done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scan_order();
        u_if.data_in = 16'h8A30;
        u_if.load    = 1'b1;
        tick();
        u_if.load = 1'b0;
        restart();
        for (int j = 0; j < 64; j++) begin
            tick();
            n_vec++;
            if (u_if.an !== exp_an(j)) begin
                n_err++; $display("FAIL scan_an j=%0d got %b want %b", j, u_if.an, exp_an(j));
            end
            n_vec++;
            if (u_if.seg !== exp_seg(j, 16'h8A30)) begin
                n_err++;
                $display("FAIL scan_seg j=%0d got %b want %b", j, u_if.seg, exp_seg(j, 16'h8A30));
            end
            n_vec++;
            if (u_if.frame_done !== ((j % 32) == 31)) begin
                n_err++; $display("FAIL scan_fd j=%0d got %b want %b", j, u_if.frame_done,
                                  ((j % 32) == 31));
            end
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] d;
        restart();
        for (int j = 0; j < 64; j++) begin
            tick();
            d = (j < 32) ? 16'h8A30 : 16'h1111;
            n_vec++;
            if (u_if.an !== exp_an(j)) begin
                n_err++; $display("FAIL tear_an j=%0d got %b want %b", j, u_if.an, exp_an(j));
            end
            n_vec++;
            if (u_if.seg !== exp_seg(j, d)) begin
                n_err++; $display("FAIL tear_seg j=%0d got %b want %b", j, u_if.seg, exp_seg(j, d));
            end
            // Load lands in slot 1 of the first frame
            u_if.load    = (j == 10);
            u_if.data_in = 16'h1111;
        end
        u_if.load = 1'b0;
    endtask

    task automatic test_load_collision();
        logic [15:0] d;
        restart();
        for (int j = 0; j < 96; j++) begin
            tick();
            d = (j < 32) ? 16'h1111 : 16'hF000;
            n_vec++;
            if (u_if.an !== exp_an(j)) begin
                n_err++; $display("FAIL coll_an j=%0d got %b want %b", j, u_if.an, exp_an(j));
            end
            n_vec++;
            if (u_if.seg !== exp_seg(j, d)) begin
                n_err++; $display("FAIL coll_seg j=%0d got %b want %b", j, u_if.seg, exp_seg(j, d));
            end
            n_vec++;
            if (u_if.frame_done !== ((j % 32) == 31)) begin
                n_err++; $display("FAIL coll_fd j=%0d got %b want %b", j, u_if.frame_done,
                                  ((j % 32) == 31));
            end
            // An older pending value, then a load sampled on the wrap edge (edge 31)
            u_if.load    = (j == 5) || (j == 30);
            u_if.data_in = (j == 5) ? 16'h2222 : 16'hF000;
        end
        u_if.load = 1'b0;
    endtask

    task automatic test_en_toggle();
        restart();
        for (int j = 0; j <= 18; j++) begin
            tick();
            n_vec++;
            if (u_if.an !== exp_an(j)) begin
                n_err++; $display("FAIL en_pre_an j=%0d got %b want %b", j, u_if.an, exp_an(j));
            end
        end
        u_if.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            u_if.load    = (k == 1);
            u_if.data_in = 16'h4567;
            tick();
            n_vec++;
            if (u_if.an !== 4'hF) begin
                n_err++; $display("FAIL en_off_an k=%0d got %b want 1111", k, u_if.an);
            end
            n_vec++;
            if (u_if.seg !== 7'b1111111) begin
                n_err++; $display("FAIL en_off_seg k=%0d got %b want 1111111", k, u_if.seg);
            end
            n_vec++;
            if (u_if.frame_done !== 1'b0) begin
                n_err++; $display("FAIL en_off_fd k=%0d got %b want 0", k, u_if.frame_done);
            end
        end
        u_if.load = 1'b0;
        u_if.en   = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            n_vec++;
            if (u_if.an !== exp_an(j)) begin
                n_err++; $display("FAIL en_on_an j=%0d got %b want %b", j, u_if.an, exp_an(j));
            end
            n_vec++;
            if (u_if.seg !== exp_seg(j, 16'h4567)) begin
                n_err++;
                $display("FAIL en_on_seg j=%0d got %b want %b", j, u_if.seg, exp_seg(j, 16'h4567));
            end
        end
    endtask

    task automatic test_lzb();
        logic [6:0] e [4];
        logic [6:0] want;
`ifdef SEG_SCAN_LZB_EN
        e = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
`else
        e = '{7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001};
`endif
        u_if.en      = 1'b0;
        u_if.data_in = 16'h0050;
        u_if.load    = 1'b1;
        tick();
        u_if.load = 1'b0;
        restart();
        for (int j = 0; j < 32; j++) begin
            tick();
            want = ((j % 8) < 2) ? 7'b1111111 : e[j / 8];
            n_vec++;
            if (u_if.an !== exp_an(j)) begin
                n_err++; $display("FAIL lzb_an j=%0d got %b want %b", j, u_if.an, exp_an(j));
            end
            n_vec++;
            if (u_if.seg !== want) begin
                n_err++; $display("FAIL lzb_seg j=%0d got %b want %b", j, u_if.seg, want);
            end
        end
    endtask

    task automatic test_async_reset();
        restart();
        repeat (12) tick();
        // Mid-cycle, mid-SHOW of digit 1
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (u_if.an !== 4'hF) begin
            n_err++; $display("FAIL areset_an got %b want 1111", u_if.an);
        end
        n_vec++;
        if (u_if.seg !== 7'b1111111) begin
            n_err++; $display("FAIL areset_seg got %b want 1111111", u_if.seg);
        end
        n_vec++;
        if (u_if.frame_done !== 1'b0) begin
            n_err++; $display("FAIL areset_fd got %b want 0", u_if.frame_done);
        end
        @(negedge clk) rst_n = 1'b1;
        // Shadow cleared by reset: digit 0 shows 0 in either build
        for (int j = 0; j < 4; j++) begin
            tick();
            n_vec++;
            if (u_if.seg !== exp_seg(j, 16'h0000)) begin
                n_err++;
                $display("FAIL areset_seg0 j=%0d got %b want %b", j, u_if.seg, exp_seg(j, 16'h0000));
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_scan_order();
        test_tear_free();
        test_load_collision();
        test_en_toggle();
        test_lzb();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
